ff_bank_mode: RTL and testbench

- Parametrised, multi-mode flip-flop register bank; successor to the single-bit SR flip-flop.
- WIDTH independent bits share one clock, enable and runtime-selectable mode (SR, JK, D, T).
- The SR forbidden input S=R=1 resolves to a defined, synthesisable value instead of X, and is reported through a pulse, a sticky flag and a saturating counter.
- Sits under control logic wherever a bank of latched status/control bits is needed.

---
 rtl/ff_bank_mode.sv | 137 +++++++++++++
 tb/tb_ff_bank_mode.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ff_bank_mode.sv
// ff_bank_mode: parametrised multi-mode flip-flop bank (SR / JK / D / T).
//
// WIDTH bits share one clock, enable and runtime mode. The SR forbidden input
// (s=r=1) resolves per ILLEGAL_POLICY instead of going to X. It is reported as:
//   - a one-cycle pulse,
//   - a sticky flag,
//   - a saturating event counter.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-high reset (loads INIT_VAL, clears flags)
//   en         update enable; 0 holds y and suppresses illegal detection
//   mode       00 SR, 01 JK, 10 D, 11 T
//   a          per-bit S / J / D / T
//   b          per-bit R / K (ignored in D and T)
//   clr_err    synchronous clear of err_sticky / err_count
//   y, yn      registered state and its complement
//   illegal    pulse: SR illegal condition seen on the previous edge
//   err_sticky set by any illegal event, held until clr_err / reset
//   err_count  illegal events (edges, not bits), saturating
//   rise, fall per-bit 0->1 / 1->0 pulses (only with FF_BANK_EDGE_DET_EN)
//
// Optional feature macro: FF_BANK_EDGE_DET_EN adds the rise/fall outputs.

// Per-bit next-state logic; purely combinational.
module ff_bank_mode_bit #(
    parameter int ILLEGAL_POLICY = 0
) (
    input  logic       q,
    input  logic       a,
    input  logic       b,
    input  logic [1:0] mode,
    output logic       d
);
    always_comb begin
        d = q;
        case (mode)
            2'b00: begin
                case ({a, b})
                    2'b01:   d = 1'b0;
                    2'b10:   d = 1'b1;
                    2'b11: begin
                        // Out-of-range policy values fall back to hold.
                        if (ILLEGAL_POLICY == 1)      d = 1'b0;
                        else if (ILLEGAL_POLICY == 2) d = 1'b1;
                        else                          d = q;
                    end
                    default: d = q;
                endcase
            end
            2'b01: begin
                case ({a, b})
                    2'b01:   d = 1'b0;
                    2'b10:   d = 1'b1;
                    2'b11:   d = ~q;
                    default: d = q;
                endcase
            end
            2'b10:   d = a;
            default: d = q ^ a;
        endcase
    end
endmodule

module ff_bank_mode #(
    parameter int               WIDTH          = 8,
    parameter int               ERRCNT_W       = 4,
    parameter int               ILLEGAL_POLICY = 0,
    parameter logic [WIDTH-1:0] INIT_VAL       = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                clr_err,
    output logic [WIDTH-1:0]    y,
    output logic [WIDTH-1:0]    yn,
`ifdef FF_BANK_EDGE_DET_EN
    output logic [WIDTH-1:0]    rise,
    output logic [WIDTH-1:0]    fall,
`endif
    output logic                illegal,
    output logic                err_sticky,
    output logic [ERRCNT_W-1:0] err_count
);
    logic [WIDTH-1:0] y_nxt;
    logic             illegal_evt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ff_bank_mode_bit #(.ILLEGAL_POLICY(ILLEGAL_POLICY)) u_bit (
            .q    (y[i]),
            .a    (a[i]),
            .b    (b[i]),
            .mode (mode),
            .d    (y_nxt[i])
        );
    end

    // Any number of colliding bits on one edge is a single event.
    assign illegal_evt = en && (mode == 2'b00) && (|(a & b));
    assign yn          = ~y;

    always_ff @(posedge clock) begin
        if (reset) begin
            y          <= INIT_VAL;
            illegal    <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else begin
            if (en) y <= y_nxt;
            illegal <= illegal_evt;
            // A clear coinciding with a new event keeps that event.
            if (clr_err) begin
                err_sticky <= illegal_evt;
                err_count  <= illegal_evt ? ERRCNT_W'(1) : '0;
            end else if (illegal_evt) begin
                err_sticky <= 1'b1;
                if (err_count != '1) err_count <= err_count + ERRCNT_W'(1);
            end
        end
    end

`ifdef FF_BANK_EDGE_DET_EN
    // Pulses are cleared on reset, so a reset-driven change of y never pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            rise <= '0;
            fall <= '0;
        end else begin
            rise <= en ? (y_nxt & ~y) : '0;
            fall <= en ? (~y_nxt & y) : '0;
        end
    end
`endif
endmodule

// File: tb/tb_ff_bank_mode.sv
module tb_ff_bank_mode;
    localparam int WIDTH    = 8;
    localparam int ERRCNT_W = 4;

    logic                clock = 1'b0;
    logic                reset, en, clr_err;
    logic [1:0]          mode;
    logic [WIDTH-1:0]    a, b, y, yn;
    logic                illegal, err_sticky;
    logic [ERRCNT_W-1:0] err_count;
`ifdef FF_BANK_EDGE_DET_EN
    logic [WIDTH-1:0]    rise, fall;
`endif

    int vectors = 0;
    int fails   = 0;

    localparam logic [1:0] SR = 2'b00, JK = 2'b01, DM = 2'b10, TM = 2'b11;

    ff_bank_mode #(
        .WIDTH(WIDTH), .ERRCNT_W(ERRCNT_W), .ILLEGAL_POLICY(2), .INIT_VAL(8'hA5)
    ) dut (
        .clock(clock), .reset(reset), .en(en), .mode(mode), .a(a), .b(b),
        .clr_err(clr_err), .y(y), .yn(yn),
`ifdef FF_BANK_EDGE_DET_EN
        .rise(rise), .fall(fall),
`endif
        .illegal(illegal), .err_sticky(err_sticky), .err_count(err_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle before sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] m,
                         input logic [7:0] av, input logic [7:0] bv, input logic c);
        reset = r; en = e; mode = m; a = av; b = bv; clr_err = c;
    endtask

    initial begin
        drive(1, 1, SR, 8'hFF, 8'hFF, 1);
        #2;
        // 1. reset overrides en/mode/illegal inputs
        step();
        chk("rst_y", y, 8'hA5);
        chk("rst_yn", yn, 8'h5A);
        chk("rst_illegal", illegal, 0);
        chk("rst_sticky", err_sticky, 0);
        chk("rst_count", err_count, 0);

        // 2. SR basic ops from 00
        drive(0, 1, DM, 8'h00, 8'h00, 0); step();
        chk("d_zero", y, 8'h00);
        drive(0, 1, SR, 8'h0F, 8'h00, 0); step();
        chk("sr_set", y, 8'h0F);
        chk("sr_set_illegal", illegal, 0);
        drive(0, 1, SR, 8'h00, 8'h03, 0); step();
        chk("sr_reset", y, 8'h0C);
        drive(0, 1, SR, 8'h00, 8'h00, 0); step();
        chk("sr_hold", y, 8'h0C);
        chk("sr_hold_yn", yn, 8'hF3);

        // 3. illegal with policy 2 (force 1)
        drive(0, 1, DM, 8'h00, 8'h00, 0); step();
        drive(0, 1, SR, 8'h81, 8'h01, 0); step();
        chk("pol2_y", y, 8'h81);
        chk("pol2_illegal", illegal, 1);
        chk("pol2_sticky", err_sticky, 1);
        chk("pol2_count", err_count, 1);
        drive(0, 1, SR, 8'h00, 8'h00, 0); step();
        chk("pulse_end", illegal, 0);
        chk("sticky_held", err_sticky, 1);
        chk("count_held", err_count, 1);
        chk("y_after", y, 8'h81);

        // en=0 suppresses detection and update
        drive(0, 0, SR, 8'hFF, 8'hFF, 0); step();
        chk("en0_illegal", illegal, 0);
        chk("en0_count", err_count, 1);
        chk("en0_y", y, 8'h81);

        // 4. clear, then saturate
        drive(0, 0, SR, 8'h00, 8'h00, 1); step();
        chk("clr_sticky", err_sticky, 0);
        chk("clr_count", err_count, 0);
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, SR, 8'h01, 8'h01, 0); step();
            chk("sat_count", err_count, (i + 1 > 15) ? 15 : i + 1);
        end
        chk("sat_illegal", illegal, 1);
        drive(0, 1, SR, 8'h10, 8'h10, 1); step();
        chk("clr_evt_count", err_count, 1);
        chk("clr_evt_sticky", err_sticky, 1);
        chk("clr_evt_illegal", illegal, 1);
        drive(0, 1, SR, 8'h00, 8'h00, 1); step();
        chk("clr2_count", err_count, 0);
        chk("clr2_sticky", err_sticky, 0);
        chk("clr2_illegal", illegal, 0);

        // 5. mode sweep
        drive(0, 1, DM, 8'h3C, 8'h00, 0); step();
        chk("d_3c", y, 8'h3C);
        drive(0, 1, JK, 8'hFF, 8'hFF, 0); step();
        chk("jk_toggle", y, 8'hC3);
        chk("jk_no_illegal", illegal, 0);
        drive(0, 1, TM, 8'h01, 8'hFF, 0); step();
        chk("t_toggle", y, 8'hC2);
        drive(0, 1, DM, 8'h55, 8'hFF, 0); step();
        chk("d_load", y, 8'h55);
        drive(0, 0, DM, 8'hAA, 8'h00, 0); step();
        chk("en0_hold", y, 8'h55);
        drive(0, 1, JK, 8'h0F, 8'hF0, 0); step();
        chk("jk_setclr", y, 8'h0F);

        // 6. edge detect (when built in)
        drive(0, 1, DM, 8'h0F, 8'h00, 0); step();
        drive(0, 1, DM, 8'hF0, 8'h00, 0); step();
        chk("d_f0", y, 8'hF0);
`ifdef FF_BANK_EDGE_DET_EN
        chk("rise", rise, 8'hF0);
        chk("fall", fall, 8'h0F);
        step();
        chk("rise_end", rise, 8'h00);
        chk("fall_end", fall, 8'h00);
`endif

        // reset mid-operation discards the edge's update
        drive(1, 1, DM, 8'h00, 8'h00, 0); step();
        chk("rst_mid_y", y, 8'hA5);
`ifdef FF_BANK_EDGE_DET_EN
        chk("rst_mid_rise", rise, 8'h00);
        chk("rst_mid_fall", fall, 8'h00);
`endif
        drive(0, 1, SR, 8'h00, 8'h00, 0); step();
        chk("post_rst_hold", y, 8'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
